// File: rtl/regwrite_trace_buffer_pkg.sv
// Shared trace-entry layout and constants for the register-write trace buffer.
// Entry width depends on the TRACE_TIMESTAMP_EN macro.
package regwrite_trace_buffer_pkg;

   localparam int unsigned TS_W     = 16;
   localparam int unsigned DROP_W   = 16;
   localparam logic [DROP_W-1:0] DROP_SAT = 16'hFFFF;

   // Entry layout, LSB first: data, register address, optional timestamp.
   function automatic int unsigned addr_lsb(int unsigned data_w);
      return data_w;
   endfunction

   function automatic int unsigned ts_lsb(int unsigned addr_w, int unsigned data_w);
      return addr_w + data_w;
   endfunction

   function automatic int unsigned entry_w(int unsigned addr_w, int unsigned data_w);
`ifdef TRACE_TIMESTAMP_EN
      return addr_w + data_w + TS_W;
`else
      return addr_w + data_w;
`endif
   endfunction

endpackage

// File: rtl/regwrite_trace_buffer_trace_fifo.sv
// Generic first-word-fall-through FIFO: wrapping pointers plus occupancy counter.
module regwrite_trace_buffer_trace_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 37,
   localparam int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [PTR_W:0]   level,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]   level_q;
   logic             do_push, do_pop;

   assign full  = (level_q == (PTR_W + 1)'(DEPTH));
   assign empty = (level_q == '0);
   assign level = level_q;

   // A push into a full FIFO is still accepted when the head leaves the same cycle.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // Head is forced to zero while empty so the outputs read zero after reset.
   assign dout = empty ? '0 : mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   level_q <= level_q + (PTR_W + 1)'(1);
            2'b01:   level_q <= level_q - (PTR_W + 1)'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/regwrite_trace_buffer.sv
// Captures nonzero-destination register writes into a FIFO drained over valid/ready.
// TRACE_TIMESTAMP_EN adds a 16-bit cycle stamp per entry and the trace_ts port.
module regwrite_trace_buffer
   import regwrite_trace_buffer_pkg::*;
#(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cap_en,
   input  logic                     wb_we,
   input  logic [ADDR_W-1:0]        wb_rd_addr,
   input  logic [DATA_W-1:0]        wb_data,
   output logic                     trace_valid,
   input  logic                     trace_ready,
   output logic [ADDR_W-1:0]        trace_addr,
   output logic [DATA_W-1:0]        trace_data,
`ifdef TRACE_TIMESTAMP_EN
   output logic [TS_W-1:0]          trace_ts,
`endif
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic [DROP_W-1:0]        drop_cnt
);

   localparam int unsigned ENTRY_W = entry_w(ADDR_W, DATA_W);
   localparam int unsigned A_LSB   = addr_lsb(DATA_W);

   logic [ENTRY_W-1:0] push_entry, head_entry;
   logic               push_req, pop, full, empty, drop;
   logic               overflow_q;
   logic [DROP_W-1:0]  drop_cnt_q;

   assign push_req = cap_en && wb_we && (wb_rd_addr != '0);
   assign pop      = trace_valid && trace_ready;
   assign drop     = push_req && full && !pop;

`ifdef TRACE_TIMESTAMP_EN
   localparam int unsigned T_LSB = ts_lsb(ADDR_W, DATA_W);
   logic [TS_W-1:0] ts_q;

   always_ff @(posedge clk) begin
      if (rst) ts_q <= '0;
      else     ts_q <= ts_q + TS_W'(1);
   end

   assign push_entry = {ts_q, wb_rd_addr, wb_data};
   assign trace_ts   = head_entry[T_LSB +: TS_W];
`else
   assign push_entry = {wb_rd_addr, wb_data};
`endif

   regwrite_trace_buffer_trace_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_req),
      .pop   (pop),
      .din   (push_entry),
      .dout  (head_entry),
      .level (level),
      .full  (full),
      .empty (empty)
   );

   assign trace_valid = !empty;
   assign trace_addr  = head_entry[A_LSB +: ADDR_W];
   assign trace_data  = head_entry[0 +: DATA_W];

   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else if (drop) begin
         overflow_q <= 1'b1;
         if (drop_cnt_q != DROP_SAT) drop_cnt_q <= drop_cnt_q + DROP_W'(1);
      end
   end

   assign overflow = overflow_q;
   assign drop_cnt = drop_cnt_q;

endmodule
